mvu_ctrl: RTL and testbench
===========================

MVU_CTRL -- requirements
Module: mvu_ctrl

Interface
REQ-001 Parameter BWBANKA, default 9, weight-bank address width.
REQ-002 Parameter BDBANKA, default 15, data-bank address width.
REQ-003 Parameter LAT, default 3, cycles from a read issue to the accumulator holding its result.
REQ-004 Ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Job-start ports: start  in  1  job start pulse; busy  out  1  job in progress; done  out  1  one-cycle job-complete pulse.
REQ-006 Job-config ports, all inputs: cfg_mode  2  multiply mode; cfg_wbase  BWBANKA  weight base; cfg_dbase  BDBANKA  input bit-plane base; cfg_obase  BDBANKA  output base; cfg_ntiles  8  tiles per output; cfg_iprec  4  input bit-planes; cfg_nout  8  outputs; cfg_pool  1  max-pool enable.
REQ-007 Outputs to one MVU lane: mul_mode  2; acc_clr  1; acc_sh  1; max_en  1; max_clr  1; max_pool  1; rdw_addr  BWBANKA; rdd_en  1; rdd_addr  BDBANKA; wrd_en  1; wrd_addr  BDBANKA.
REQ-008 Grant inputs: rdd_grnt  in  1  data-read grant; wrd_grnt  in  1  data-write grant.

Function
REQ-009 The block SHALL use states IDLE, RUN, DRAIN, WB and FIN.
REQ-010 In IDLE, a start pulse SHALL latch all cfg_* inputs, zero the counters o, p and t, and move to RUN; busy SHALL be high in every state except IDLE.
REQ-011 A start pulse while busy is high SHALL be ignored.
REQ-012 If cfg_ntiles, cfg_iprec or cfg_nout is 0, a start pulse SHALL go directly to FIN with no read or write traffic.
REQ-013 The loop order SHALL be: o = 0..nout-1 outer; bit-plane p = 0..iprec-1, where p = 0 is the MSB, middle; t = 0..ntiles-1 inner.
REQ-014 In RUN, rdd_en SHALL be high; a step issues only in a cycle with rdd_en and rdd_grnt both high.
REQ-015 During a stall (rdd_grnt low), all addresses, acc_clr, acc_sh and the counters SHALL hold.
REQ-016 rdw_addr SHALL equal (wbase + o*ntiles + t) mod 2^BWBANKA.
REQ-017 rdd_addr SHALL equal (dbase + (iprec-1-p)*ntiles + t) mod 2^BDBANKA.
REQ-018 acc_clr SHALL be high on the step p=0, t=0.
REQ-019 acc_sh SHALL be high on steps with t=0 and p>0 (Horner shift-add).
REQ-020 acc_clr and acc_sh SHALL both be low in every cycle other than those given in REQ-018 and REQ-019.
REQ-021 The step after the last issue of an output (p=iprec-1, t=ntiles-1) SHALL be DRAIN, which holds for exactly LAT cycles with rdd_en low, then enters WB.
REQ-022 In WB, wrd_en SHALL be high and wrd_addr SHALL equal (obase + o) mod 2^BDBANKA, held until the cycle in which wrd_grnt is high.
REQ-023 On that granted WB cycle, the block SHALL increment o and go to RUN, or go to FIN if o = nout-1.
REQ-024 max_en SHALL equal pool AND (WB granted cycle).
REQ-025 max_clr SHALL be high on the first WB cycle of o=0 when pool=1.
REQ-026 max_pool SHALL equal the latched pool flag while busy is high.
REQ-027 mul_mode SHALL equal the latched mode while busy is high, and 0 otherwise.
REQ-028 FIN SHALL last one cycle with done high, then return to IDLE; start is not accepted in FIN.
REQ-029 All outputs SHALL be registered.
REQ-030 The counters SHALL use widths sized so that o*ntiles reaches at most 255*255 with no overflow before the modulo is applied.

Reset
REQ-031 While rst_n is low: state=IDLE; all counters and latched cfg=0; every output=0.
REQ-032 rst_n asserted mid-job SHALL abort the job with no done pulse and no further wrd_en; the first cycle after release SHALL be IDLE.

Structure
REQ-033 Package mvu_pkg SHALL hold BWBANKA, BDBANKA, the state enum and the mul_mode encodings.
REQ-034 The nested t/p/o counter with wrap and terminal flags SHALL be the sub-module mvu_loopctr; all other logic SHALL be in mvu_ctrl.

Verification
REQ-035 Basic job (ntiles=2, iprec=2, nout=1, wbase=5, dbase=100, obase=200, grant always high, LAT=3): rdd_addr SHALL be 102,103,100,101 and rdw_addr 5,6,5,6; acc_clr on step 1, acc_sh on step 3; wrd_en at 200 exactly 4 cycles after the last issue; done one cycle later.
REQ-036 Stall: rdd_grnt low for 5 cycles mid-RUN -> addresses and flags SHALL be frozen and the total issued step count SHALL be unchanged.
REQ-037 Write stall: wrd_grnt low for 3 cycles -> wrd_en and wrd_addr SHALL be held, and the next output SHALL start only after the grant.
REQ-038 Wrap: wbase=510, ntiles=4 -> rdw_addr SHALL be 510,511,0,1.
REQ-039 Degenerate/abort: cfg_nout=0 -> done SHALL pulse with zero rdd_en/wrd_en; rst_n low mid-RUN -> all outputs SHALL be 0 and there SHALL be no done pulse.
REQ-040 Pool: cfg_pool=1, nout=3 -> max_clr SHALL be high only at o=0 WB, and max_en SHALL be high exactly 3 times.

Source files
------------

// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared widths, FSM states and multiply-mode encodings for the MVU controller
package mvu_pkg;
    localparam int BWBANKA = 9;
    localparam int BDBANKA = 15;
    localparam int CNT_W   = 8;
    localparam int PREC_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WB,
        FIN
    } mvu_state_e;

    typedef enum logic [1:0] {
        MUL_OFF = 2'd0,
        MUL_BIN = 2'd1,
        MUL_TER = 2'd2,
        MUL_INT = 2'd3
    } mul_mode_e;
endpackage

// File: rtl/mvu_ctrl_if.sv
// rtl/mvu_ctrl_if.sv - control/grant bundle between the MVU controller and one MVU lane
interface mvu_ctrl_if #(
    parameter int BWBANKA = mvu_pkg::BWBANKA,
    parameter int BDBANKA = mvu_pkg::BDBANKA
);
    logic [1:0]         mul_mode;
    logic               acc_clr;
    logic               acc_sh;
    logic               max_en;
    logic               max_clr;
    logic               max_pool;
    logic [BWBANKA-1:0] rdw_addr;
    logic               rdd_en;
    logic [BDBANKA-1:0] rdd_addr;
    logic               wrd_en;
    logic [BDBANKA-1:0] wrd_addr;
    logic               rdd_grnt;
    logic               wrd_grnt;

    modport master (
        output mul_mode, acc_clr, acc_sh, max_en, max_clr, max_pool,
        output rdw_addr, rdd_en, rdd_addr, wrd_en, wrd_addr,
        input  rdd_grnt, wrd_grnt
    );

    modport slave (
        input  mul_mode, acc_clr, acc_sh, max_en, max_clr, max_pool,
        input  rdw_addr, rdd_en, rdd_addr, wrd_en, wrd_addr,
        output rdd_grnt, wrd_grnt
    );
endinterface

// File: rtl/mvu_loopctr.sv
// rtl/mvu_loopctr.sv - nested tile/bit-plane/output counter with wrap and terminal flags
module mvu_loopctr
    import mvu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              step,
    input  logic              next_o,
    input  logic [CNT_W-1:0]  ntiles,
    input  logic [PREC_W-1:0] iprec,
    input  logic [CNT_W-1:0]  nout,
    output logic [CNT_W-1:0]  t_d,
    output logic [PREC_W-1:0] p_d,
    output logic [CNT_W-1:0]  o_d,
    output logic              t_last,
    output logic              p_last,
    output logic              o_last
);
    logic [CNT_W-1:0]  t_q;
    logic [PREC_W-1:0] p_q;
    logic [CNT_W-1:0]  o_q;

    assign t_last = (t_q == ntiles - CNT_W'(1));
    assign p_last = (p_q == iprec - PREC_W'(1));
    assign o_last = (o_q == nout - CNT_W'(1));

    // t and p wrap to zero after the last issue of an output; o only moves on write-back
    always_comb begin
        t_d = t_q;
        p_d = p_q;
        o_d = o_q;
        if (clr) begin
            t_d = '0;
            p_d = '0;
            o_d = '0;
        end else if (next_o) begin
            t_d = '0;
            p_d = '0;
            o_d = o_q + CNT_W'(1);
        end else if (step) begin
            if (t_last) begin
                t_d = '0;
                p_d = p_last ? '0 : p_q + PREC_W'(1);
            end else begin
                t_d = t_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
            p_q <= '0;
            o_q <= '0;
        end else begin
            t_q <= t_d;
            p_q <= p_d;
            o_q <= o_d;
        end
    end
endmodule

// File: rtl/mvu_ctrl.sv
// rtl/mvu_ctrl.sv - job sequencer driving weight/data reads, Horner accumulate and write-back for one MVU lane
module mvu_ctrl #(
    parameter int BWBANKA = mvu_pkg::BWBANKA,
    parameter int BDBANKA = mvu_pkg::BDBANKA,
    parameter int LAT     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic [1:0]         cfg_mode,
    input  logic [BWBANKA-1:0] cfg_wbase,
    input  logic [BDBANKA-1:0] cfg_dbase,
    input  logic [BDBANKA-1:0] cfg_obase,
    input  logic [7:0]         cfg_ntiles,
    input  logic [3:0]         cfg_iprec,
    input  logic [7:0]         cfg_nout,
    input  logic               cfg_pool,
    mvu_ctrl_if.master         lane
);
    import mvu_pkg::*;

    localparam logic [7:0] DRAIN_LAST = 8'(LAT - 1);

    mvu_state_e         state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [BWBANKA-1:0] wbase_q, wbase_d;
    logic [BDBANKA-1:0] dbase_q, dbase_d, obase_q, obase_d;
    logic [7:0]         ntiles_q, ntiles_d, nout_q, nout_d;
    logic [3:0]         iprec_q, iprec_d;
    logic               pool_q, pool_d;
    logic [7:0]         drain_q, drain_d;

    logic               cnt_clr, cnt_step, cnt_next_o;
    logic [7:0]         t_d, o_d;
    logic [3:0]         p_d;
    logic               t_last, p_last, o_last;

    logic               busy_q, busy_d, done_q, done_d;
    logic [1:0]         mul_mode_q, mul_mode_d;
    logic               acc_clr_q, acc_clr_d, acc_sh_q, acc_sh_d;
    logic               max_en_q, max_en_d, max_clr_q, max_clr_d, max_pool_q, max_pool_d;
    logic               rdd_en_q, rdd_en_d, wrd_en_q, wrd_en_d;
    logic [BWBANKA-1:0] rdw_addr_q, rdw_addr_d;
    logic [BDBANKA-1:0] rdd_addr_q, rdd_addr_d, wrd_addr_q, wrd_addr_d;
    logic [15:0]        wprod, dprod;
    logic [3:0]         plane;

    mvu_loopctr u_loopctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .step   (cnt_step),
        .next_o (cnt_next_o),
        .ntiles (ntiles_q),
        .iprec  (iprec_q),
        .nout   (nout_q),
        .t_d    (t_d),
        .p_d    (p_d),
        .o_d    (o_d),
        .t_last (t_last),
        .p_last (p_last),
        .o_last (o_last)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wbase_d    = wbase_q;
        dbase_d    = dbase_q;
        obase_d    = obase_q;
        ntiles_d   = ntiles_q;
        iprec_d    = iprec_q;
        nout_d     = nout_q;
        pool_d     = pool_q;
        drain_d    = drain_q;
        cnt_clr    = 1'b0;
        cnt_step   = 1'b0;
        cnt_next_o = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                mode_d   = cfg_mode;
                wbase_d  = cfg_wbase;
                dbase_d  = cfg_dbase;
                obase_d  = cfg_obase;
                ntiles_d = cfg_ntiles;
                iprec_d  = cfg_iprec;
                nout_d   = cfg_nout;
                pool_d   = cfg_pool;
                cnt_clr  = 1'b1;
                if (cfg_ntiles == 8'd0 || cfg_iprec == 4'd0 || cfg_nout == 8'd0)
                    state_d = FIN;
                else
                    state_d = RUN;
            end
            RUN: if (lane.rdd_grnt) begin
                cnt_step = 1'b1;
                if (t_last && p_last) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST)
                    state_d = WB;
                else
                    drain_d = drain_q + 8'd1;
            end
            WB: if (lane.wrd_grnt) begin
                if (o_last) begin
                    state_d = FIN;
                end else begin
                    cnt_next_o = 1'b1;
                    state_d    = RUN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are precomputed from next state/counters so every output leaves a flop
    always_comb begin
        wprod      = 16'(o_d) * 16'(ntiles_d);
        plane      = iprec_d - 4'd1 - p_d;
        dprod      = 16'(plane) * 16'(ntiles_d);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        mul_mode_d = busy_d ? mode_d : 2'(MUL_OFF);
        max_pool_d = busy_d & pool_d;
        rdd_en_d   = (state_d == RUN);
        acc_clr_d  = rdd_en_d && p_d == 4'd0 && t_d == 8'd0;
        acc_sh_d   = rdd_en_d && p_d != 4'd0 && t_d == 8'd0;
        wrd_en_d   = (state_d == WB);
        max_en_d   = pool_q && state_q == WB && lane.wrd_grnt;
        max_clr_d  = pool_d && state_d == WB && state_q != WB && o_d == 8'd0;
        rdw_addr_d = rdw_addr_q;
        rdd_addr_d = rdd_addr_q;
        wrd_addr_d = wrd_addr_q;
        if (rdd_en_d) begin
            rdw_addr_d = wbase_d + BWBANKA'(wprod) + BWBANKA'(t_d);
            rdd_addr_d = dbase_d + BDBANKA'(dprod) + BDBANKA'(t_d);
        end
        if (wrd_en_d)
            wrd_addr_d = obase_d + BDBANKA'(o_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            wbase_q    <= '0;
            dbase_q    <= '0;
            obase_q    <= '0;
            ntiles_q   <= '0;
            iprec_q    <= '0;
            nout_q     <= '0;
            pool_q     <= 1'b0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mul_mode_q <= '0;
            acc_clr_q  <= 1'b0;
            acc_sh_q   <= 1'b0;
            max_en_q   <= 1'b0;
            max_clr_q  <= 1'b0;
            max_pool_q <= 1'b0;
            rdd_en_q   <= 1'b0;
            wrd_en_q   <= 1'b0;
            rdw_addr_q <= '0;
            rdd_addr_q <= '0;
            wrd_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wbase_q    <= wbase_d;
            dbase_q    <= dbase_d;
            obase_q    <= obase_d;
            ntiles_q   <= ntiles_d;
            iprec_q    <= iprec_d;
            nout_q     <= nout_d;
            pool_q     <= pool_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mul_mode_q <= mul_mode_d;
            acc_clr_q  <= acc_clr_d;
            acc_sh_q   <= acc_sh_d;
            max_en_q   <= max_en_d;
            max_clr_q  <= max_clr_d;
            max_pool_q <= max_pool_d;
            rdd_en_q   <= rdd_en_d;
            wrd_en_q   <= wrd_en_d;
            rdw_addr_q <= rdw_addr_d;
            rdd_addr_q <= rdd_addr_d;
            wrd_addr_q <= wrd_addr_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign lane.mul_mode = mul_mode_q;
    assign lane.acc_clr  = acc_clr_q;
    assign lane.acc_sh   = acc_sh_q;
    assign lane.max_en   = max_en_q;
    assign lane.max_clr  = max_clr_q;
    assign lane.max_pool = max_pool_q;
    assign lane.rdw_addr = rdw_addr_q;
    assign lane.rdd_en   = rdd_en_q;
    assign lane.rdd_addr = rdd_addr_q;
    assign lane.wrd_en   = wrd_en_q;
    assign lane.wrd_addr = wrd_addr_q;
endmodule

// File: tb/tb_mvu_ctrl.sv
// tb/tb_mvu_ctrl.sv - directed, table-driven self-checking bench for mvu_ctrl
module tb_mvu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, start, busy, done;
    logic [1:0]  cfg_mode;
    logic [8:0]  cfg_wbase;
    logic [14:0] cfg_dbase, cfg_obase;
    logic [7:0]  cfg_ntiles, cfg_nout;
    logic [3:0]  cfg_iprec;
    logic        cfg_pool;
    logic [49:0] all_out;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mvu_ctrl_if #(.BWBANKA(9), .BDBANKA(15)) lane();

    mvu_ctrl #(.BWBANKA(9), .BDBANKA(15), .LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cfg_mode(cfg_mode), .cfg_wbase(cfg_wbase), .cfg_dbase(cfg_dbase),
        .cfg_obase(cfg_obase), .cfg_ntiles(cfg_ntiles), .cfg_iprec(cfg_iprec),
        .cfg_nout(cfg_nout), .cfg_pool(cfg_pool), .lane(lane)
    );

    assign all_out = {busy, done, lane.mul_mode, lane.acc_clr, lane.acc_sh, lane.max_en,
                      lane.max_clr, lane.max_pool, lane.rdw_addr, lane.rdd_en, lane.rdd_addr,
                      lane.wrd_en, lane.wrd_addr};

    typedef struct {
        int nt, ip, no, wb, db, ob, pool, mode, rs_at, rs_len, ws_len;
        int e_iss, e_wr, e_men, e_mclr, e_clra, e_cyc, e_rdd0, e_rdw0, e_rdw3, e_wlast, e_nclr, e_nsh;
    } job_t;

    typedef struct {
        int rdd_en, rdd, rdw, clr, sh, wen, wad, dn;
    } trace_t;

    job_t   jobs[9];
    trace_t trace[10];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input job_t j);
        cfg_ntiles = 8'(j.nt);
        cfg_iprec  = 4'(j.ip);
        cfg_nout   = 8'(j.no);
        cfg_wbase  = 9'(j.wb);
        cfg_dbase  = 15'(j.db);
        cfg_obase  = 15'(j.ob);
        cfg_pool   = 1'(j.pool);
        cfg_mode   = 2'(j.mode);
    endtask

    task automatic run_job(input job_t j, input string nm);
        int iss = 0, wr = 0, men = 0, mclr = 0, clra = -1, cyc = 0, dones = 0;
        int rdd0 = -1, rdw0 = -1, rdw3 = -1, wlast = -1, nclr = 0, nsh = 0, viol = 0;
        int wbcnt = 0, mode0 = -1, busy0 = -1;
        logic [26:0] rsnap, rcur;
        logic [14:0] wsnap;
        set_cfg(j);
        start = 1'b1;
        lane.rdd_grnt = 1'b1;
        lane.wrd_grnt = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 400; k++) begin
            start = (k == 3 || k == j.e_cyc);
            lane.rdd_grnt = !(j.rs_len > 0 && k >= j.rs_at && k < j.rs_at + j.rs_len);
            lane.wrd_grnt = !(lane.wrd_en && wbcnt < j.ws_len);
            if (k == 1) begin
                mode0 = int'(lane.mul_mode);
                busy0 = int'(busy);
            end
            rcur = {lane.rdd_en, lane.rdd_addr, lane.rdw_addr, lane.acc_clr, lane.acc_sh};
            if (lane.rdd_en && lane.rdd_grnt) begin
                if (iss == 0) begin
                    rdd0 = int'(lane.rdd_addr);
                    rdw0 = int'(lane.rdw_addr);
                end
                if (iss == 3) rdw3 = int'(lane.rdw_addr);
                if (lane.acc_clr) nclr++;
                if (lane.acc_sh) nsh++;
                iss++;
            end
            if ((lane.acc_clr || lane.acc_sh) && !lane.rdd_en) viol++;
            if (!lane.rdd_grnt) begin
                if (k == j.rs_at) rsnap = rcur;
                else if (rcur != rsnap) viol++;
            end
            if (lane.wrd_en) begin
                if (!lane.wrd_grnt) begin
                    if (wbcnt == 0) wsnap = lane.wrd_addr;
                    else if (lane.wrd_addr != wsnap) viol++;
                    if (lane.rdd_en) viol++;
                end else begin
                    wr++;
                    wlast = int'(lane.wrd_addr);
                end
                wbcnt++;
            end
            if (lane.max_en) men++;
            if (lane.max_clr) begin
                mclr++;
                clra = int'(lane.wrd_addr);
            end
            if (done) begin
                dones++;
                cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        lane.rdd_grnt = 1'b1;
        lane.wrd_grnt = 1'b1;
        check({nm, ".idle"}, int'({busy, done, lane.rdd_en, lane.wrd_en, lane.mul_mode, lane.max_pool}), 0);
        check({nm, ".done"}, dones, 1);
        check({nm, ".cycles"}, cyc, j.e_cyc);
        check({nm, ".issues"}, iss, j.e_iss);
        check({nm, ".writes"}, wr, j.e_wr);
        check({nm, ".max_en"}, men, j.e_men);
        check({nm, ".max_clr"}, mclr, j.e_mclr);
        check({nm, ".max_clr_addr"}, clra, j.e_clra);
        check({nm, ".rdd0"}, rdd0, j.e_rdd0);
        check({nm, ".rdw0"}, rdw0, j.e_rdw0);
        check({nm, ".rdw3"}, rdw3, j.e_rdw3);
        check({nm, ".wrd_last"}, wlast, j.e_wlast);
        check({nm, ".acc_clr"}, nclr, j.e_nclr);
        check({nm, ".acc_sh"}, nsh, j.e_nsh);
        check({nm, ".frozen"}, viol, 0);
        check({nm, ".mode"}, mode0, j.mode);
        check({nm, ".busy"}, busy0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary by time limit, expected finish");
        $fatal(1);
    end

    initial begin
        jobs[0] = '{2,2,1,5,100,200,0,1, 0,0,0,  4,1,0,0,-1,9,102,5,6,200,1,1};
        jobs[1] = '{4,1,2,510,0,7,1,2,   0,0,0,  8,2,2,1,7,17,0,510,1,8,2,0};
        jobs[2] = '{3,3,2,0,1000,30000,0,3, 0,0,0, 18,2,0,0,-1,27,1006,0,0,30001,2,4};
        jobs[3] = '{1,4,3,20,50,32767,1,0, 0,0,0, 12,3,3,1,32767,25,53,20,20,1,3,9};
        jobs[4] = '{0,2,1,5,100,200,1,1, 0,0,0,  0,0,0,0,-1,1,-1,-1,-1,-1,0,0};
        jobs[5] = '{2,2,0,5,100,200,0,2, 0,0,0,  0,0,0,0,-1,1,-1,-1,-1,-1,0,0};
        jobs[6] = '{2,0,1,5,100,200,0,3, 0,0,0,  0,0,0,0,-1,1,-1,-1,-1,-1,0,0};
        jobs[7] = '{2,2,1,5,100,200,0,1, 2,5,0,  4,1,0,0,-1,14,102,5,6,200,1,1};
        jobs[8] = '{2,1,2,0,0,10,1,2,    0,0,3,  4,2,2,1,10,16,0,0,3,11,2,0};

        trace[0] = '{1,102,5,1,0,0,0,0};
        trace[1] = '{1,103,6,0,0,0,0,0};
        trace[2] = '{1,100,5,0,1,0,0,0};
        trace[3] = '{1,101,6,0,0,0,0,0};
        trace[4] = '{0,101,6,0,0,0,0,0};
        trace[5] = '{0,101,6,0,0,0,0,0};
        trace[6] = '{0,101,6,0,0,0,0,0};
        trace[7] = '{0,101,6,0,0,1,200,0};
        trace[8] = '{0,101,6,0,0,0,200,1};
        trace[9] = '{0,101,6,0,0,0,200,0};

        rst_n = 1'b0;
        start = 1'b0;
        lane.rdd_grnt = 1'b1;
        lane.wrd_grnt = 1'b1;
        set_cfg(jobs[0]);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'(all_out != 50'd0), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // cycle-exact trace of the basic two-tile, two-plane job
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("trace%0d.rdd_en", c), int'(lane.rdd_en), trace[c].rdd_en);
            check($sformatf("trace%0d.rdd_addr", c), int'(lane.rdd_addr), trace[c].rdd);
            check($sformatf("trace%0d.rdw_addr", c), int'(lane.rdw_addr), trace[c].rdw);
            check($sformatf("trace%0d.acc_clr", c), int'(lane.acc_clr), trace[c].clr);
            check($sformatf("trace%0d.acc_sh", c), int'(lane.acc_sh), trace[c].sh);
            check($sformatf("trace%0d.wrd_en", c), int'(lane.wrd_en), trace[c].wen);
            check($sformatf("trace%0d.wrd_addr", c), int'(lane.wrd_addr), trace[c].wad);
            check($sformatf("trace%0d.done", c), int'(done), trace[c].dn);
            if (c < 9) begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 9; i++)
            run_job(jobs[i], $sformatf("job%0d", i));

        // abort mid-RUN with an asynchronous reset
        begin
            int dn = 0, we = 0;
            set_cfg(jobs[2]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("abort.running", int'(lane.rdd_en), 1);
            rst_n = 1'b0;
            #1;
            check("abort.async_zero", int'(all_out != 50'd0), 0);
            @(posedge clk); #1;
            check("abort.held_zero", int'(all_out != 50'd0), 0);
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("abort.idle_after", int'(busy), 0);
            for (int k = 0; k < 20; k++) begin
                if (done) dn++;
                if (lane.wrd_en || lane.rdd_en) we++;
                @(posedge clk); #1;
            end
            check("abort.no_done", dn, 0);
            check("abort.no_traffic", we, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
